// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared state encoding and divider helpers for clk_en_gen
package clk_en_gen_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN} state_t;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int NUM_CH_DEF = 3;
  localparam int CH_IDX_W = ch_idx_w(NUM_CH_DEF);
  function automatic int clamp_div_phase(input int div, input int phase);
    int d;
    d = (div == 0) ? 1 : div;
    return (phase >= d) ? d - 1 : phase;
  endfunction
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: one channel's divider counter, shadow register and gated enable strobe
module clk_en_div import clk_en_gen_pkg::*; #(
  parameter int DIV_W = 8,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rel,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             pending,
  output logic             clk_en
);
  logic [DIV_W-1:0] div, phase, sh_div, sh_phase, cnt, eff_div, eff_phase;
  logic strobe, wrap;
  always_comb begin
    eff_div = (div == '0) ? DIV_W'(1) : div;
    eff_phase = DIV_W'(clamp_div_phase(int'(div), int'(phase)));
    wrap = cnt >= eff_div - 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      div <= DIV_RST;
      phase <= '0;
      sh_div <= '0;
      sh_phase <= '0;
      pending <= 1'b0;
      strobe <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      strobe <= cnt == eff_phase;
      if (wrap && pending) begin
        div <= sh_div;
        phase <= sh_phase;
      end
      if (wr) begin
        sh_div <= wr_div;
        sh_phase <= wr_phase;
        pending <= 1'b1;
      end else if (wrap) pending <= 1'b0;
    end
  assign clk_en = strobe & rel;
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: N-channel clock-enable generator with lock-qualified staggered resets; CLK_EN_GEN_LOSS_CNT_EN adds lock_loss_cnt
module clk_en_gen import clk_en_gen_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int DIV_W = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd30, 8'd8, 8'd80},
  parameter int LOCK_CYCLES = 64,
  parameter int RST_STAGGER = 4,
  localparam int CH_W = ch_idx_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] ch_rst_n,
`ifdef CLK_EN_GEN_LOSS_CNT_EN
  output logic              locked,
  output logic [7:0]        lock_loss_cnt
`else
  output logic              locked
`endif
);
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam int ST_W = $clog2(RST_STAGGER + 1);
  localparam int EXT = 2 ** CH_W;
  state_t state;
  logic [LC_W-1:0] lock_cnt;
  logic [ST_W-1:0] stg;
  logic rdy, hs;
  logic [NUM_CH-1:0] pending, nxt_rel;
  logic [EXT-1:0] pend_ext;
  assign pend_ext = EXT'(pending);
  assign cfg_ready = rdy && !pend_ext[cfg_ch];
  assign hs = cfg_valid && cfg_ready;
  assign nxt_rel = (ch_rst_n << 1) | NUM_CH'(1);
  always_ff @(posedge refclk)
    if (!reset_n) begin
      state <= WAIT_LOCK;
      lock_cnt <= '0;
      stg <= '0;
      ch_rst_n <= '0;
      locked <= 1'b0;
      rdy <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (state != WAIT_LOCK && !pll_lock) begin
        state <= WAIT_LOCK;
        lock_cnt <= '0;
        ch_rst_n <= '0;
        locked <= 1'b0;
      end else if (state == WAIT_LOCK) begin
        lock_cnt <= pll_lock ? lock_cnt + 1'b1 : '0;
        if (pll_lock && lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
          lock_cnt <= '0;
          stg <= '0;
          ch_rst_n <= NUM_CH'(1);
          state <= (NUM_CH == 1) ? RUN : RELEASE;
          locked <= (NUM_CH == 1);
        end
      end else if (state == RELEASE) begin
        if (stg == ST_W'(RST_STAGGER - 1)) begin
          stg <= '0;
          ch_rst_n <= nxt_rel;
          if (nxt_rel[NUM_CH-1]) begin
            state <= RUN;
            locked <= 1'b1;
          end
        end else stg <= stg + 1'b1;
      end
    end
`ifdef CLK_EN_GEN_LOSS_CNT_EN
  always_ff @(posedge refclk)
    if (!reset_n) lock_loss_cnt <= '0;
    else if (state != WAIT_LOCK && !pll_lock && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_div #(.DIV_W(DIV_W), .DIV_RST(DIV_INIT[i*DIV_W +: DIV_W])) u_div (
      .clk(refclk),
      .rst_n(reset_n),
      .rel(ch_rst_n[i]),
      .wr(hs && cfg_ch == CH_W'(i)),
      .wr_div(cfg_div),
      .wr_phase(cfg_phase),
      .pending(pending[i]),
      .clk_en(clk_en[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed and randomized checks of clk_en_gen against a time-based reference model
module tb_clk_en_gen;
  import clk_en_gen_pkg::*;
  localparam int N = 3, W = 8, LC = 64, ST = 4;
  localparam logic [N*W-1:0] INIT = {8'd30, 8'd8, 8'd80};
  logic refclk = 1'b0, reset_n = 1'b0, pll_lock = 1'b0, cfg_valid = 1'b0;
  logic [CH_IDX_W-1:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0, cfg_phase = '0;
  logic cfg_ready, locked;
  logic [N-1:0] clk_en, ch_rst_n;
`ifdef CLK_EN_GEN_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif
  int total = 0, bad = 0;
  int e, last_low, m_loss;
  bit m_rdy, armed = 0;
  int m_div[N], m_ph[N], m_base[N], s_div[N], s_ph[N];
  bit m_pend[N];
  logic [N-1:0] x_en, x_rst, prev_rst = '0;
  logic prev_locked = 1'b0;
  int rise[N+1], prev_pulse[N], period[N];

  always #5 refclk = ~refclk;

  clk_en_gen #(.NUM_CH(N), .DIV_W(W), .DIV_INIT(INIT), .LOCK_CYCLES(LC), .RST_STAGGER(ST)) dut (
    .refclk(refclk), .reset_n(reset_n), .pll_lock(pll_lock),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .clk_en(clk_en), .ch_rst_n(ch_rst_n),
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    .locked(locked), .lock_loss_cnt(lock_loss_cnt)
`else
    .locked(locked)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction
  function automatic int peff(input int d, input int p);
    return (p >= deff(d)) ? deff(d) - 1 : p;
  endfunction
  // channel i is out of reset once lock has been continuously high for LC + i*ST edges
  function automatic bit rel(input int i);
    return (e - last_low) >= LC + i * ST;
  endfunction
  function automatic bit x_ready();
    return m_rdy && (int'(cfg_ch) >= N || !m_pend[cfg_ch]);
  endfunction

  task automatic model_reset();
    e = 0; last_low = 0; m_rdy = 0; m_loss = 0;
    for (int i = 0; i < N; i++) begin
      m_div[i] = int'(INIT[i*W +: W]); m_ph[i] = 0; m_base[i] = 0;
      m_pend[i] = 0; s_div[i] = 0; s_ph[i] = 0;
    end
  endtask

  task automatic tick();
    bit acc, was_rel;
    int d, c;
    #1;
    if (armed) chk("cfg_ready", 32'(cfg_ready), 32'(x_ready()));
    acc = cfg_valid && x_ready();
    @(posedge refclk);
    armed = 1;
    if (!reset_n) begin
      model_reset();
      x_en = '0;
    end else begin
      was_rel = rel(0);
      e++;
      if (!pll_lock) begin
        last_low = e;
        if (was_rel && m_loss < 255) m_loss++;
      end
      for (int i = 0; i < N; i++) begin
        d = deff(m_div[i]);
        c = (e - 1 - m_base[i]) % d;
        x_en[i] = rel(i) && c == peff(m_div[i], m_ph[i]);
        if (m_pend[i] && c == d - 1) begin
          m_div[i] = s_div[i]; m_ph[i] = s_ph[i]; m_base[i] = e; m_pend[i] = 0;
        end
      end
      if (acc && int'(cfg_ch) < N) begin
        m_pend[cfg_ch] = 1; s_div[cfg_ch] = int'(cfg_div); s_ph[cfg_ch] = int'(cfg_phase);
      end
      m_rdy = 1;
    end
    for (int i = 0; i < N; i++) x_rst[i] = rel(i);
    #1;
    chk("clk_en", 32'(clk_en), 32'(x_en));
    chk("ch_rst_n", 32'(ch_rst_n), 32'(x_rst));
    chk("locked", 32'(locked), 32'(rel(N-1)));
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    for (int i = 0; i < N; i++) begin
      if (clk_en[i] === 1'b1) begin period[i] = e - prev_pulse[i]; prev_pulse[i] = e; end
      if (ch_rst_n[i] === 1'b1 && prev_rst[i] !== 1'b1) rise[i] = e;
    end
    if (locked === 1'b1 && prev_locked !== 1'b1) rise[N] = e;
    prev_rst = ch_rst_n;
    prev_locked = locked;
  endtask

  task automatic cfg_write(input int ch, input int d, input int p);
    int k;
    k = 0;
    cfg_valid = 1; cfg_ch = CH_IDX_W'(ch); cfg_div = W'(d); cfg_phase = W'(p);
    #1;
    while (cfg_ready !== 1'b1 && k < 300) begin tick(); k++; end
    chk("cfg_write_wait", 32'(cfg_ready), 32'(1));
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    int k, drop_e;
    model_reset();
    for (int i = 0; i < N; i++) begin prev_pulse[i] = 0; period[i] = 0; end
    for (int i = 0; i <= N; i++) rise[i] = 0;
    reset_n = 0;
    repeat (3) tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
    chk("rst_ch_rst_n", 32'(ch_rst_n), 32'(0));
    chk("rst_clk_en", 32'(clk_en), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    reset_n = 1; pll_lock = 1;
    repeat (80) tick();
    chk("rise_ch0", rise[0], 64);
    chk("rise_ch1", rise[1], 68);
    chk("rise_ch2", rise[2], 72);
    chk("rise_locked", rise[N], 72);
    repeat (240) tick();
    chk("period_ch0", period[0], 80);
    chk("period_ch1", period[1], 8);
    chk("period_ch2", period[2], 30);
    cfg_write(1, 4, 2);
    cfg_valid = 1;
    #1;
    chk("second_write_stall", 32'(cfg_ready), 32'(0));
    cfg_write(1, 4, 2);
    repeat (40) tick();
    chk("period_ch1_new", period[1], 4);
    pll_lock = 0;
    tick();
    drop_e = e;
    chk("loss_ch_rst_n", 32'(ch_rst_n), 32'(0));
    chk("loss_clk_en", 32'(clk_en), 32'(0));
    chk("loss_locked", 32'(locked), 32'(0));
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    chk("loss_cnt_one", 32'(lock_loss_cnt), 32'(1));
`endif
    pll_lock = 1;
    k = 0;
    while (ch_rst_n[0] !== 1'b1 && k < 100) begin tick(); k++; end
    chk("relock_ch0_delay", e - drop_e, 64);
    cfg_valid = 1; cfg_ch = '0; cfg_div = W'(7); cfg_phase = W'(3);
    tick();
    cfg_valid = 0; reset_n = 0;
    #1;
    chk("pending_before_rst", 32'(cfg_ready), 32'(0));
    tick();
    chk("midrel_ch_rst_n", 32'(ch_rst_n), 32'(0));
    chk("midrel_clk_en", 32'(clk_en), 32'(0));
    chk("midrel_locked", 32'(locked), 32'(0));
    chk("midrel_cfg_ready", 32'(cfg_ready), 32'(0));
    tick();
    reset_n = 1;
    rise[N] = 0;
    tick();
    chk("post_rst_ready", 32'(cfg_ready), 32'(1));
    repeat (100) tick();
    chk("rise_locked_again", rise[N], 72);
    cfg_write(2, 0, 0);
    cfg_write(0, 5, 9);
    repeat (100) tick();
    chk("ch2_div0_high", 32'(clk_en[2]), 32'(1));
    chk("ch2_div0_period", period[2], 1);
    chk("ch0_clamp_period", period[0], 5);
    repeat (800) begin
      pll_lock = ($urandom_range(0, 199) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = CH_IDX_W'($urandom_range(0, 3));
      cfg_div = W'($urandom_range(0, 12));
      cfg_phase = W'($urandom_range(0, 12));
      tick();
    end
    cfg_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
